// File: rtl/serial_shifter_pkg.sv
// Shared definitions for the serial operand-2 shifter: shift type codes,
// FSM state encoding and the iteration-count bounds.
package serial_shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Largest iteration count: LSL/LSR by more than 32 needs one extra step
  // to push the last data bit out of the carry as well.
  localparam int MAX_ITER = 33;
  localparam int CNT_W    = 6;

  typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/serial_shifter_count_norm.sv
// Turns an ARM shift type/amount into the number of single-bit steps the
// serial shifter must perform, and flags the RRX special case.
module shift_count_norm
  import serial_shifter_pkg::*;
(
  input  logic [1:0] Shift_Type,
  input  logic       Imm_Form,
  input  logic [7:0] Shift_Num,
  output count_t     k,
  output logic       is_rrx
);

  shift_type_e typ;
  logic [7:0]  n;

  // Normalize the effective amount into a bounded step count.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case statements can infer a latch.
    k      = '0;
    is_rrx = 1'b0;
    typ    = shift_type_e'(Shift_Type);
    // Immediate form carries its 5-bit amount in bits [5:1].
    n      = Imm_Form ? {3'b000, Shift_Num[5:1]} : Shift_Num;

    if (n == 8'd0) begin
      // Register form with zero amount is a pass-through (k stays 0).
      // Immediate zero encodes LSR/ASR #32 and RRX; LSL #0 is a pass-through.
      if (Imm_Form) begin
        case (typ)
          SHIFT_LSL:            k = '0;
          SHIFT_LSR, SHIFT_ASR: k = count_t'(32);
          SHIFT_ROR: begin
            k      = count_t'(1);
            is_rrx = 1'b1;
          end
        endcase
      end
    end else begin
      case (typ)
        // Amounts above 32 saturate at 33 so the carry ends up cleared.
        SHIFT_LSL, SHIFT_LSR:
          k = (n > 8'(MAX_ITER)) ? count_t'(MAX_ITER) : n[CNT_W-1:0];
        // Beyond 32 an arithmetic shift only keeps replicating the sign.
        SHIFT_ASR:
          k = (n > 8'd32) ? count_t'(32) : n[CNT_W-1:0];
        // Rotation is modulo 32; a nonzero multiple of 32 does a full turn
        // so the carry picks up the top bit.
        SHIFT_ROR:
          k = (n[4:0] == 5'd0) ? count_t'(32) : {1'b0, n[4:0]};
      endcase
    end
  end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle ARM operand-2 shifter: one bit position per clock, result and
// carry held stable from the done pulse until the next accepted start.
module serial_shifter
  import serial_shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       Shift_Type,
  input  logic             Imm_Form,
  input  logic [7:0]       Shift_Num,
  input  logic [WIDTH-1:0] Shift_Data,
  input  logic             CF,
  output logic [WIDTH-1:0] Shift_Out,
  output logic             Shift_Carry_Out,
  output logic             busy,
  output logic             done
);

  count_t      norm_k;
  logic        norm_rrx;

  state_e      state;
  count_t      cnt;
  shift_type_e op_q;
  logic        rrx_q;
  logic        cf_q;
  logic [WIDTH-1:0] data_q;
  logic        carry_q;
  logic        busy_q;
  logic        done_q;

  shift_count_norm u_norm (
    .Shift_Type (Shift_Type),
    .Imm_Form   (Imm_Form),
    .Shift_Num  (Shift_Num),
    .k          (norm_k),
    .is_rrx     (norm_rrx)
  );

  // FSM, step counter and the data/carry shift registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= SHIFT_LSL;
      rrx_q   <= 1'b0;
      cf_q    <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_q  <= Shift_Data;
            carry_q <= CF;
            cf_q    <= CF;
            op_q    <= shift_type_e'(Shift_Type);
            rrx_q   <= norm_rrx;
            cnt     <= norm_k;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - count_t'(1);
            if (rrx_q) begin
              {data_q, carry_q} <= {cf_q, data_q};
            end else begin
              case (op_q)
                SHIFT_LSL: {carry_q, data_q} <= {data_q, 1'b0};
                SHIFT_LSR: {data_q, carry_q} <= {1'b0, data_q};
                SHIFT_ASR: {data_q, carry_q} <= {data_q[WIDTH-1], data_q};
                SHIFT_ROR: {data_q, carry_q} <= {data_q[0], data_q};
              endcase
            end
          end
        end
      endcase
    end
  end

  assign Shift_Out       = data_q;
  assign Shift_Carry_Out = carry_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: directed table, multi-cycle corner
// sequences, randomized operations against a behavioural model, and an
// exhaustive sweep of the count normalizer.
module tb_serial_shifter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   Shift_Type;
  logic         Imm_Form;
  logic [7:0]   Shift_Num;
  logic [W-1:0] Shift_Data;
  logic         CF;
  logic [W-1:0] Shift_Out;
  logic         Shift_Carry_Out;
  logic         busy;
  logic         done;

  logic [1:0]   n_type;
  logic         n_imm;
  logic [7:0]   n_num;
  logic [5:0]   n_k;
  logic         n_rrx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_shifter #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .Shift_Type      (Shift_Type),
    .Imm_Form        (Imm_Form),
    .Shift_Num       (Shift_Num),
    .Shift_Data      (Shift_Data),
    .CF              (CF),
    .Shift_Out       (Shift_Out),
    .Shift_Carry_Out (Shift_Carry_Out),
    .busy            (busy),
    .done            (done)
  );

  shift_count_norm u_norm_ref (
    .Shift_Type (n_type),
    .Imm_Form   (n_imm),
    .Shift_Num  (n_num),
    .k          (n_k),
    .is_rrx     (n_rrx)
  );

  typedef struct {
    logic [1:0]   typ;
    logic         imm;
    logic [7:0]   num;
    logic [W-1:0] data;
    logic         cf;
    logic [W-1:0] exp_out;
    logic         exp_c;
    int           exp_k;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Step count from the ARM amount rules.
  function automatic int ref_k(input logic [1:0] t, input logic imm, input logic [7:0] num,
                               output logic rrx);
    int n;
    rrx = 1'b0;
    n = imm ? int'(num[5:1]) : int'(num);
    if (n == 0) begin
      if (!imm || t == 2'd0) return 0;
      if (t == 2'd3) begin
        rrx = 1'b1;
        return 1;
      end
      return 32;
    end
    case (t)
      2'd0, 2'd1: return (n > 33) ? 33 : n;
      2'd2:       return (n > 32) ? 32 : n;
      default:    return (n % 32 == 0) ? 32 : n % 32;
    endcase
  endfunction

  // Whole-word result and carry computed directly with wide shifts.
  task automatic ref_result(input logic [1:0] t, input logic imm, input logic [7:0] num,
                            input logic [W-1:0] data, input logic cf,
                            output logic [W-1:0] res, output logic c);
    int n;
    int m;
    logic [63:0] wide;
    logic signed [63:0] swide;
    n = imm ? int'(num[5:1]) : int'(num);
    if (n == 0 && (!imm || t == 2'd0)) begin
      res = data; c = cf;
    end else if (n == 0 && t == 2'd3) begin
      res = {cf, data[W-1:1]}; c = data[0];
    end else begin
      if (n == 0) n = 32;
      case (t)
        2'd0: begin
          if (n > 32) begin res = '0; c = 1'b0; end
          else begin wide = {32'b0, data} << n; res = wide[31:0]; c = wide[32]; end
        end
        2'd1: begin
          if (n > 32) begin res = '0; c = 1'b0; end
          else begin wide = {data, 32'b0} >> n; res = wide[63:32]; c = wide[31]; end
        end
        2'd2: begin
          m = (n > 32) ? 32 : n;
          swide = {data, 32'b0};
          swide = swide >>> m;
          res = swide[63:32]; c = swide[31];
        end
        default: begin
          m = n % 32;
          if (m == 0) begin res = data; c = data[W-1]; end
          else begin wide = {data, data} >> m; res = wide[31:0]; c = data[m-1]; end
        end
      endcase
    end
  endtask

  // Issue one operation from a negedge and return at the negedge of its done
  // cycle. Inputs are scrambled after acceptance to prove they were latched.
  // poke >= 0 raises start again after that many edges into the operation.
  task automatic run_op(input string name, input logic [1:0] t, input logic imm,
                        input logic [7:0] num, input logic [W-1:0] data, input logic cf,
                        input logic [W-1:0] exp_out, input logic exp_c, input int exp_k,
                        input int poke);
    int edges;
    int bad_busy;
    Shift_Type = t; Imm_Form = imm; Shift_Num = num; Shift_Data = data; CF = cf;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    Shift_Type = 2'($urandom); Imm_Form = 1'($urandom); Shift_Num = 8'($urandom);
    Shift_Data = $urandom; CF = ~cf;
    edges = 0;
    bad_busy = 0;
    while (!done && edges < 40) begin
      if (busy !== 1'b1) bad_busy++;
      if (edges == poke) start = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
    end
    check({name, " latency"}, 64'(edges), 64'(exp_k + 1));
    check({name, " busy_while_shifting"}, 64'(bad_busy), 64'd0);
    check({name, " busy_in_done"}, 64'(busy), 64'd0);
    check({name, " out"}, 64'(Shift_Out), 64'(exp_out));
    check({name, " carry"}, 64'(Shift_Carry_Out), 64'(exp_c));
  endtask

  initial begin
    logic [W-1:0] e_out;
    logic         e_c;
    logic         e_rrx;
    int           e_k;
    int           done_seen;

    rst = 1'b1; start = 1'b0; Shift_Type = '0; Imm_Form = 1'b0; Shift_Num = '0;
    Shift_Data = '0; CF = 1'b0;

    // Exhaustive normalizer sweep.
    for (int t = 0; t < 4; t++) begin
      for (int im = 0; im < 2; im++) begin
        for (int nn = 0; nn < 256; nn++) begin
          n_type = 2'(t); n_imm = 1'(im); n_num = 8'(nn);
          #1;
          e_k = ref_k(n_type, n_imm, n_num, e_rrx);
          if (n_k !== 6'(e_k) || n_rrx !== e_rrx) begin
            check($sformatf("norm t%0d i%0d n%0d", t, im, nn), {n_rrx, n_k}, {e_rrx, 6'(e_k)});
          end else begin
            checks++;
          end
        end
      end
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out", 64'(Shift_Out), 64'd0);
    check("reset carry", 64'(Shift_Carry_Out), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    //        typ    imm   num     data           cf    exp_out        c     k
    vecs[0]  = '{2'd0, 1'b0, 8'd1,   32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 1};
    vecs[1]  = '{2'd1, 1'b1, 8'd0,   32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 32};
    vecs[2]  = '{2'd0, 1'b0, 8'd40,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 33};
    vecs[3]  = '{2'd2, 1'b0, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 32};
    vecs[4]  = '{2'd3, 1'b1, 8'd0,   32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1};
    vecs[5]  = '{2'd3, 1'b0, 8'd64,  32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 32};
    vecs[6]  = '{2'd3, 1'b0, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0};
    vecs[7]  = '{2'd0, 1'b0, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 32};
    vecs[8]  = '{2'd1, 1'b0, 8'd33,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 33};
    vecs[9]  = '{2'd3, 1'b1, 8'd2,   32'h0000_0003, 1'b0, 32'h8000_0001, 1'b1, 1};
    vecs[10] = '{2'd0, 1'b1, 8'd0,   32'h0000_00A5, 1'b1, 32'h0000_00A5, 1'b1, 0};
    vecs[11] = '{2'd2, 1'b0, 8'd4,   32'h8000_0010, 1'b1, 32'hF800_0001, 1'b0, 4};

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].typ, vecs[i].imm, vecs[i].num, vecs[i].data,
             vecs[i].cf, vecs[i].exp_out, vecs[i].exp_c, vecs[i].exp_k, -1);
      @(negedge clk);
      check($sformatf("vec%0d hold_out", i), 64'(Shift_Out), 64'(vecs[i].exp_out));
      check($sformatf("vec%0d hold_carry", i), 64'(Shift_Carry_Out), 64'(vecs[i].exp_c));
      check($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
    end

    // Start pulsed while busy must be ignored.
    run_op("ignore_start", 2'd0, 1'b0, 8'd20, 32'h0000_F00F, 1'b0,
           32'h00F0_0000, 1'b1, 20, 5);

    // Back-to-back: a new start in the done cycle is accepted directly.
    run_op("b2b_a", 2'd1, 1'b0, 8'd4, 32'h0000_00F8, 1'b0, 32'h0000_000F, 1'b1, 4, -1);
    run_op("b2b_b", 2'd0, 1'b0, 8'd2, 32'h4000_0001, 1'b0, 32'h0000_0004, 1'b1, 2, -1);
    @(negedge clk);

    // Reset mid-operation aborts and no done follows.
    Shift_Type = 2'd0; Imm_Form = 1'b0; Shift_Num = 8'd20; Shift_Data = 32'hDEAD_BEEF; CF = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset out", 64'(Shift_Out), 64'd0);
    check("midreset carry", 64'(Shift_Carry_Out), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    rst = 1'b0;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("midreset no_done", 64'(done_seen), 64'd0);

    // Randomized operations against the model.
    for (int i = 0; i < 150; i++) begin
      logic [1:0]   t;
      logic         imm;
      logic [7:0]   num;
      logic [W-1:0] data;
      logic         cf;
      int           sel;
      t = 2'($urandom); imm = 1'($urandom); data = $urandom; cf = 1'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0: num = 8'd0;
        1: num = 8'd32;
        2: num = 8'd33;
        3: num = 8'd64;
        4: num = 8'd1;
        default: num = 8'($urandom);
      endcase
      if (imm && sel < 4) num = 8'd0;
      ref_result(t, imm, num, data, cf, e_out, e_c);
      e_k = ref_k(t, imm, num, e_rrx);
      run_op($sformatf("rand%0d t%0d i%0d n%0d", i, t, imm, num), t, imm, num, data, cf,
             e_out, e_c, e_k, -1);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
